// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the Avalon-MM memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_t;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: be_of = 4'b0001 << a;
      SZ_HALF: be_of = 4'b0011 << a;
      default: be_of = 4'b1111;
    endcase
  endfunction

  // The unused size encoding is handled like a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [1:0] a,
                                           input logic sgn, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (size)
      SZ_BYTE: load_ext = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: load_ext = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Avalon-MM bus between the memory access unit (master) and the memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr_i, first asserted request wins.
module mem_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_CH)) sum = sum - (IDX_W+1)'(NUM_CH);
      c = sum[IDX_W-1:0];
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Avalon-MM master shared by NUM_CH requesters with round-robin grant and lane steering.
// Define MEM_TIMEOUT_EN to add a waitrequest watchdog of TIMEOUT_CYCLES cycles.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*2-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_signed,
  input  logic [NUM_CH*32-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     busy,
  mem_access_unit_if.master        avm
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [NUM_CH-1:0] arb_req, gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;

  assign arb_req = (state_q == IDLE && !reset) ? req_valid : '0;

  mem_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          owner_d = gnt_idx;
          write_d = req_write[gnt_idx];
          addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          size_d  = req_size[gnt_idx*2 +: 2];
          sgn_d   = req_signed[gnt_idx];
          wdata_d = req_wdata[gnt_idx*32 +: 32];
          rdata_d = '0;
          ptr_d   = (gnt_idx == IDX_W'(NUM_CH-1)) ? '0 : gnt_idx + IDX_W'(1);
          state_d = misaligned(req_size[gnt_idx*2 +: 2], req_addr[gnt_idx*ADDR_W +: 2])
                    ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (!avm.waitrequest) begin
          rdata_d = write_q ? '0 : load_ext(size_q, addr_q[1:0], sgn_q, avm.readdata);
          state_d = RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Bus outputs come straight from the latched request, so they stay frozen across waitrequest.
  assign avm.read       = (state_q == ACCESS) && !write_q;
  assign avm.write      = (state_q == ACCESS) && write_q;
  assign avm.address    = (state_q == ACCESS) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign avm.byteenable = (state_q == ACCESS) ? be_of(size_q, addr_q[1:0]) : '0;
  assign avm.writedata  = (state_q == ACCESS && write_q) ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;

  assign req_ready  = gnt;
  assign resp_valid = (state_q == RESP || state_q == ERR) ? (NUM_CH'(1) << owner_q) : '0;
  assign resp_err   = (state_q == ERR);
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (two channels, 32-bit addresses).
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        req_valid, req_ready, req_write, req_signed, resp_valid;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*2-1:0]      req_size;
  logic [NUM_CH*32-1:0]     req_wdata;
  logic [31:0]              resp_rdata;
  logic                     resp_err, busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .avm        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] wd);
    req_write[ch]            = wr;
    req_addr[ch*ADDR_W +: 32] = addr;
    req_size[ch*2 +: 2]      = size;
    req_signed[ch]           = sgn;
    req_wdata[ch*32 +: 32]   = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_signed = '0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    bus.waitrequest = 1'b0;
    bus.readdata = '0;
    cyc(); cyc();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_read",  32'(bus.read),  32'h0);
    chk("rst_write", 32'(bus.write), 32'h0);
    chk("rst_resp",  32'(resp_valid), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    reset = 1'b0;
    cyc();

    // 1: ch1 LW 0x1000, zero wait states
    set_req(1, 1'b0, 32'h1000, SZ_WORD, 1'b0, 32'h0);
    req_valid = 2'b10;
    bus.readdata = 32'hDEADBEEF;
    #1 chk("t1_grant", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0;
    chk("t1_read",  32'(bus.read), 32'h1);
    chk("t1_write", 32'(bus.write), 32'h0);
    chk("t1_addr",  bus.address, 32'h1000);
    chk("t1_be",    32'(bus.byteenable), 32'hF);
    chk("t1_busy",  32'(busy), 32'h1);
    cyc();
    chk("t1_resp",  32'(resp_valid), 32'h2);
    chk("t1_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t1_err",   32'(resp_err), 32'h0);
    chk("t1_rdoff", 32'(bus.read), 32'h0);
    cyc();
    chk("t1_idle",  32'(busy), 32'h0);
    chk("t1_resp1", 32'(resp_valid), 32'h0);

    // 2: LB / LBU at 0x1003
    set_req(0, 1'b0, 32'h1003, SZ_BYTE, 1'b1, 32'h0);
    req_valid = 2'b01;
    bus.readdata = 32'h80000000;
    #1 chk("t2_grant", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    chk("t2_addr", bus.address, 32'h1000);
    chk("t2_be",   32'(bus.byteenable), 32'h8);
    cyc();
    chk("t2_lb", resp_rdata, 32'hFFFFFF80);
    cyc();
    set_req(0, 1'b0, 32'h1003, SZ_BYTE, 1'b0, 32'h0);
    req_valid = 2'b01;
    #1 chk("t2_grant_u", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    cyc();
    chk("t2_lbu", resp_rdata, 32'h00000080);
    cyc();

    // 3: SH 0x2002 with five wait states
    set_req(1, 1'b1, 32'h2002, SZ_HALF, 1'b0, 32'h0000ABCD);
    req_valid = 2'b10;
    bus.waitrequest = 1'b1;
    #1 chk("t3_grant", 32'(req_ready), 32'h2);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) req_valid = '0;
      if (k == 6) bus.waitrequest = 1'b0;
      chk("t3_write", 32'(bus.write), 32'h1);
      chk("t3_addr",  bus.address, 32'h2000);
      chk("t3_be",    32'(bus.byteenable), 32'hC);
      chk("t3_wdata", bus.writedata, 32'hABCD0000);
      chk("t3_noresp", 32'(resp_valid), 32'h0);
    end
    cyc();
    chk("t3_resp",  32'(resp_valid), 32'h2);
    chk("t3_rdata", resp_rdata, 32'h0);
    cyc();
    chk("t3_single", 32'(resp_valid), 32'h0);

    // 4: both channels valid continuously -> alternating grants
    set_req(0, 1'b0, 32'h4000, SZ_WORD, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h4004, SZ_WORD, 1'b0, 32'h0);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_grant", 32'(req_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
      cyc();
      chk("t4_addr", bus.address, (i % 2 == 1) ? 32'h4004 : 32'h4000);
      cyc();
      chk("t4_resp", 32'(resp_valid), (i % 2 == 1) ? 32'h2 : 32'h1);
      cyc();
    end
    req_valid = '0;

    // 5: misaligned LW -> error without a bus cycle
    set_req(0, 1'b0, 32'h1002, SZ_WORD, 1'b0, 32'h0);
    req_valid = 2'b01;
    #1 chk("t5_grant", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    chk("t5_read",  32'(bus.read), 32'h0);
    chk("t5_write", 32'(bus.write), 32'h0);
    chk("t5_resp",  32'(resp_valid), 32'h1);
    chk("t5_err",   32'(resp_err), 32'h1);
    cyc();
    chk("t5_idle",  32'(busy), 32'h0);

    // 6: reset during a stalled access; pointer must restart at 0
    set_req(0, 1'b0, 32'h3000, SZ_WORD, 1'b0, 32'h0);
    bus.waitrequest = 1'b1;
    req_valid = 2'b01;
    #1 chk("t6_grant", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    chk("t6_read", 32'(bus.read), 32'h1);
    reset = 1'b1;
    cyc();
    chk("t6_rdoff", 32'(bus.read), 32'h0);
    chk("t6_noresp", 32'(resp_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    req_valid = 2'b11;
    #1 chk("t6_ptr0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    cyc();
    chk("t6_resp", 32'(resp_valid), 32'h1);
    cyc();

`ifdef MEM_TIMEOUT_EN
    set_req(0, 1'b0, 32'h5000, SZ_WORD, 1'b0, 32'h0);
    bus.waitrequest = 1'b1;
    req_valid = 2'b01;
    #1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req_valid = '0;
      chk("tmo_read", 32'(bus.read), 32'h1);
    end
    cyc();
    chk("tmo_rdoff", 32'(bus.read), 32'h0);
    chk("tmo_resp",  32'(resp_valid), 32'h1);
    chk("tmo_err",   32'(resp_err), 32'h1);
    bus.waitrequest = 1'b0;
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
